c2f_req_arb: RTL and testbench

//  Round-robin arbiter and response router that shares the single C2F request/response port of rc

---
 rtl/c2f_req_arb.sv | 189 ++++++++++++++++++
 tb/tb_c2f_req_arb.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c2f_req_arb.sv
// Round-robin arbiter sharing one C2F request/response port between NUM_REQ requesters.
// Tracks one outstanding read per requester, routes responses by ThreadID, times out lost reads.
//   state   | meaning
//   ST_IDLE | no read outstanding for this requester
//   ST_WAIT | read granted, waiting for RD_RSP or timeout
module c2f_req_arb #(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                    QClk,
    input  logic                    RstQnnnL,
    input  logic [NUM_REQ-1:0]      ReqValid,
    input  logic [2*NUM_REQ-1:0]    ReqOpcode,
    input  logic [32*NUM_REQ-1:0]   ReqAddress,
    input  logic [32*NUM_REQ-1:0]   ReqData,
    output logic [NUM_REQ-1:0]      ReqReady,
    output logic [NUM_REQ-1:0]      RspValid,
    output logic [31:0]             RspData,
    output logic [NUM_REQ-1:0]      RspTimeout,
    output logic                    C2F_ReqValidQ500H,
    output logic [1:0]              C2F_ReqOpcodeQ500H,
    output logic [1:0]              C2F_ReqThreadIDQ500H,
    output logic [31:0]             C2F_ReqAddressQ500H,
    output logic [31:0]             C2F_ReqDataQ500H,
    input  logic                    C2F_RspValidQ502H,
    input  logic [1:0]              C2F_RspOpcodeQ502H,
    input  logic [1:0]              C2F_RspThreadIDQ502H,
    input  logic [31:0]             C2F_RspDataQ502H,
    input  logic                    C2F_RspStall
);

    localparam logic [1:0] OP_RD     = 2'd0;
    localparam logic [1:0] OP_WR     = 2'd1;
    localparam logic [1:0] OP_RD_RSP = 2'd2;

    localparam int            TW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TERM = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } rd_state_e;

    rd_state_e       state_q [NUM_REQ];
    rd_state_e       state_d [NUM_REQ];
    logic [TW-1:0]   timer_q [NUM_REQ];
    logic [TW-1:0]   timer_d [NUM_REQ];

    logic            run_q, run_d;
    logic [1:0]      rr_q, rr_d;
    logic            out_valid_q, out_valid_d;
    logic [1:0]      out_op_q, out_op_d;
    logic [1:0]      out_tid_q, out_tid_d;
    logic [31:0]     out_addr_q, out_addr_d;
    logic [31:0]     out_data_q, out_data_d;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] rsp_hit;
    logic [NUM_REQ-1:0] expire;
    logic               grant_any;
    logic [1:0]         grant_idx;
    logic [1:0]         sel_op;
    logic [31:0]        sel_addr;
    logic [31:0]        sel_data;

    // run_q keeps grants off until the first clock after reset release
    assign run_d = 1'b1;

    always_comb begin
        int idx;
        idx       = 0;
        eligible  = '0;
        ReqReady  = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = ReqValid[i] &&
                          !(ReqOpcode[2*i +: 2] == OP_RD && state_q[i] == ST_WAIT);
        end
        if (run_q && !C2F_RspStall) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(rr_q) + k;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                for (int j = 0; j < NUM_REQ; j++) begin
                    if (!grant_any && j == idx && eligible[j]) begin
                        grant_any = 1'b1;
                        grant_idx = 2'(j);
                    end
                end
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            ReqReady[j] = grant_any && (grant_idx == 2'(j));
        end
    end

    always_comb begin
        sel_op   = OP_RD;
        sel_addr = '0;
        sel_data = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant_idx == 2'(j)) begin
                sel_op   = ReqOpcode[2*j +: 2];
                sel_addr = ReqAddress[32*j +: 32];
                sel_data = ReqData[32*j +: 32];
            end
        end
        // the stage retires whenever stall is low; a grant may reload it in that same cycle
        out_valid_d = out_valid_q && C2F_RspStall;
        out_op_d    = out_op_q;
        out_tid_d   = out_tid_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        rr_d        = rr_q;
        if (grant_any) begin
            out_valid_d = 1'b1;
            out_op_d    = sel_op;
            out_tid_d   = grant_idx;
            out_addr_d  = sel_addr;
            out_data_d  = sel_data;
            rr_d        = (int'(grant_idx) + 1 >= NUM_REQ) ? 2'd0 : grant_idx + 2'd1;
        end
    end

    always_comb begin
        rsp_hit = '0;
        expire  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = timer_q[i];
            rsp_hit[i] = C2F_RspValidQ502H && C2F_RspOpcodeQ502H == OP_RD_RSP &&
                         C2F_RspThreadIDQ502H == 2'(i) && state_q[i] == ST_WAIT;
            // a response arriving on the expiry cycle takes precedence over the timeout
            expire[i]  = (TIMEOUT_CYC != 0) && state_q[i] == ST_WAIT &&
                         timer_q[i] == TERM && !rsp_hit[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (ReqReady[i] && ReqOpcode[2*i +: 2] == OP_RD) begin
                        state_d[i] = ST_WAIT;
                        timer_d[i] = '0;
                    end
                end
                ST_WAIT: begin
                    if (rsp_hit[i] || expire[i]) state_d[i] = ST_IDLE;
                    else                         timer_d[i] = timer_q[i] + TW'(1);
                end
                default: state_d[i] = ST_IDLE;
            endcase
        end
    end

    assign RspValid             = rsp_hit;
    assign RspTimeout           = expire;
    assign RspData              = (|rsp_hit) ? C2F_RspDataQ502H : 32'd0;
    assign C2F_ReqValidQ500H    = out_valid_q;
    assign C2F_ReqOpcodeQ500H   = out_op_q;
    assign C2F_ReqThreadIDQ500H = out_tid_q;
    assign C2F_ReqAddressQ500H  = out_addr_q;
    assign C2F_ReqDataQ500H     = out_data_q;

    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            run_q       <= 1'b0;
            rr_q        <= 2'd0;
            out_valid_q <= 1'b0;
            out_op_q    <= OP_RD;
            out_tid_q   <= 2'd0;
            out_addr_q  <= 32'd0;
            out_data_q  <= 32'd0;
            for (int i = 0; i < NUM_REQ; i++) begin
                state_q[i] <= ST_IDLE;
                timer_q[i] <= '0;
            end
        end else begin
            run_q       <= run_d;
            rr_q        <= rr_d;
            out_valid_q <= out_valid_d;
            out_op_q    <= out_op_d;
            out_tid_q   <= out_tid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
            end
        end
    end

endmodule

// File: tb/tb_c2f_req_arb.sv
// Bench for c2f_req_arb: directed scenarios plus randomized traffic against a cycle-stamp reference model.
module tb_c2f_req_arb;

    localparam int         NREQ      = 2;
    localparam int         TMO       = 16;
    localparam logic [1:0] OP_RD     = 2'd0;
    localparam logic [1:0] OP_WR     = 2'd1;
    localparam logic [1:0] OP_RD_RSP = 2'd2;

    logic          QClk = 1'b0;
    logic          RstQnnnL;
    logic [1:0]    ReqValid;
    logic [3:0]    ReqOpcode;
    logic [63:0]   ReqAddress;
    logic [63:0]   ReqData;
    logic [1:0]    ReqReady;
    logic [1:0]    RspValid;
    logic [31:0]   RspData;
    logic [1:0]    RspTimeout;
    logic          C2F_ReqValidQ500H;
    logic [1:0]    C2F_ReqOpcodeQ500H;
    logic [1:0]    C2F_ReqThreadIDQ500H;
    logic [31:0]   C2F_ReqAddressQ500H;
    logic [31:0]   C2F_ReqDataQ500H;
    logic          C2F_RspValidQ502H;
    logic [1:0]    C2F_RspOpcodeQ502H;
    logic [1:0]    C2F_RspThreadIDQ502H;
    logic [31:0]   C2F_RspDataQ502H;
    logic          C2F_RspStall;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 QClk = ~QClk;

    c2f_req_arb #(.NUM_REQ(NREQ), .TIMEOUT_CYC(TMO)) dut (
        .QClk(QClk), .RstQnnnL(RstQnnnL),
        .ReqValid(ReqValid), .ReqOpcode(ReqOpcode), .ReqAddress(ReqAddress), .ReqData(ReqData),
        .ReqReady(ReqReady), .RspValid(RspValid), .RspData(RspData), .RspTimeout(RspTimeout),
        .C2F_ReqValidQ500H(C2F_ReqValidQ500H), .C2F_ReqOpcodeQ500H(C2F_ReqOpcodeQ500H),
        .C2F_ReqThreadIDQ500H(C2F_ReqThreadIDQ500H), .C2F_ReqAddressQ500H(C2F_ReqAddressQ500H),
        .C2F_ReqDataQ500H(C2F_ReqDataQ500H), .C2F_RspValidQ502H(C2F_RspValidQ502H),
        .C2F_RspOpcodeQ502H(C2F_RspOpcodeQ502H), .C2F_RspThreadIDQ502H(C2F_RspThreadIDQ502H),
        .C2F_RspDataQ502H(C2F_RspDataQ502H), .C2F_RspStall(C2F_RspStall)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        ReqValid             = '0;
        ReqOpcode            = {OP_RD, OP_RD};
        ReqAddress           = '0;
        ReqData              = '0;
        C2F_RspValidQ502H    = 1'b0;
        C2F_RspOpcodeQ502H   = OP_RD_RSP;
        C2F_RspThreadIDQ502H = 2'd0;
        C2F_RspDataQ502H     = '0;
        C2F_RspStall         = 1'b0;
    endtask

    task automatic do_reset();
        RstQnnnL = 1'b0;
        clear_inputs();
        repeat (2) @(posedge QClk);
        #1 RstQnnnL = 1'b1;
        @(posedge QClk);
    endtask

    task automatic next_cycle();
        @(posedge QClk);
        #1;
    endtask

    task automatic send_rsp(input logic [1:0] op, input logic [1:0] tid, input logic [31:0] d);
        C2F_RspValidQ502H    = 1'b1;
        C2F_RspOpcodeQ502H   = op;
        C2F_RspThreadIDQ502H = tid;
        C2F_RspDataQ502H     = d;
    endtask

    task automatic test_reset();
        do_reset();
        next_cycle();
        ReqValid = 2'b01; ReqOpcode = {OP_WR, OP_RD}; ReqAddress = {32'h0, 32'h40};
        @(negedge QClk);
        n_cmp++;
        if (ReqReady !== 2'b01) begin n_fail++; $display("FAIL reset_pre_grant: got %b want 01", ReqReady); end
        next_cycle();
        ReqValid = 2'b11; ReqOpcode = {OP_WR, OP_WR};
        #2 RstQnnnL = 1'b0;
        #1;
        n_cmp++;
        if (ReqReady !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", ReqReady); end
        n_cmp++;
        if (C2F_ReqValidQ500H !== 1'b0) begin n_fail++; $display("FAIL reset_c2f_valid: got %b want 0", C2F_ReqValidQ500H); end
        n_cmp++;
        if (C2F_ReqOpcodeQ500H !== OP_RD || C2F_ReqThreadIDQ500H !== 2'd0 || C2F_ReqAddressQ500H !== 32'd0)
            begin n_fail++; $display("FAIL reset_c2f_fields: got op %0d tid %0d addr %h want 0 0 0",
                C2F_ReqOpcodeQ500H, C2F_ReqThreadIDQ500H, C2F_ReqAddressQ500H); end
        n_cmp++;
        if (RspValid !== 2'b00 || RspTimeout !== 2'b00) begin n_fail++;
            $display("FAIL reset_rsp: got valid %b timeout %b want 00 00", RspValid, RspTimeout); end
        clear_inputs();
        repeat (2) @(posedge QClk);
        #1 RstQnnnL = 1'b1;
        @(posedge QClk);
        next_cycle();
        send_rsp(OP_RD_RSP, 2'd0, 32'h1234_5678);
        @(negedge QClk);
        n_cmp++;
        if (RspValid !== 2'b00) begin n_fail++; $display("FAIL reset_pending_cleared: got %b want 00", RspValid); end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_wr_alternate();
        logic [1:0] exp_tid;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            ReqValid   = 2'b11;
            ReqOpcode  = {OP_WR, OP_WR};
            ReqAddress = {32'h0000_00B1, 32'h0000_00A0};
            ReqData    = {32'h1111_0001, 32'h0000_0000};
            @(negedge QClk);
            n_cmp++;
            if (ReqReady !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin n_fail++;
                $display("FAIL wr_alt_grant c=%0d: got %b", c, ReqReady); end
            if (c > 0) begin
                exp_tid = 2'((c - 1) % 2);
                n_cmp++;
                if (C2F_ReqValidQ500H !== 1'b1 || C2F_ReqThreadIDQ500H !== exp_tid ||
                    C2F_ReqOpcodeQ500H !== OP_WR ||
                    C2F_ReqAddressQ500H !== (exp_tid == 2'd1 ? 32'hB1 : 32'hA0)) begin n_fail++;
                    $display("FAIL wr_alt_out c=%0d: got v%b tid %0d addr %h want v1 tid %0d",
                        c, C2F_ReqValidQ500H, C2F_ReqThreadIDQ500H, C2F_ReqAddressQ500H, exp_tid); end
            end
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_stall_hold();
        do_reset();
        next_cycle();
        ReqValid = 2'b01; ReqOpcode = {OP_WR, OP_RD};
        ReqAddress = {32'h0000_0300, 32'h0000_0100}; ReqData = {32'h3, 32'h5};
        @(negedge QClk);
        n_cmp++;
        if (ReqReady !== 2'b01) begin n_fail++; $display("FAIL stall_grant: got %b want 01", ReqReady); end
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            ReqValid     = (c <= 4) ? 2'b10 : 2'b00;
            C2F_RspStall = (c <= 3);
            @(negedge QClk);
            if (c <= 4) begin
                n_cmp++;
                if (C2F_ReqValidQ500H !== 1'b1 || C2F_ReqAddressQ500H !== 32'h100 ||
                    C2F_ReqOpcodeQ500H !== OP_RD || C2F_ReqThreadIDQ500H !== 2'd0) begin n_fail++;
                    $display("FAIL stall_hold c=%0d: got v%b addr %h op %0d tid %0d want v1 addr 100 op 0 tid 0",
                        c, C2F_ReqValidQ500H, C2F_ReqAddressQ500H, C2F_ReqOpcodeQ500H, C2F_ReqThreadIDQ500H); end
                n_cmp++;
                if (ReqReady !== ((c == 4) ? 2'b10 : 2'b00)) begin n_fail++;
                    $display("FAIL stall_ready c=%0d: got %b", c, ReqReady); end
            end else if (c == 5) begin
                n_cmp++;
                if (C2F_ReqValidQ500H !== 1'b1 || C2F_ReqThreadIDQ500H !== 2'd1 ||
                    C2F_ReqAddressQ500H !== 32'h300) begin n_fail++;
                    $display("FAIL stall_reload: got v%b tid %0d addr %h want v1 tid 1 addr 300",
                        C2F_ReqValidQ500H, C2F_ReqThreadIDQ500H, C2F_ReqAddressQ500H); end
            end else begin
                n_cmp++;
                if (C2F_ReqValidQ500H !== 1'b0) begin n_fail++;
                    $display("FAIL stall_retire: got %b want 0", C2F_ReqValidQ500H); end
            end
        end
        clear_inputs();
    endtask

    task automatic test_rd_response();
        do_reset();
        for (int c = 0; c <= 5; c++) begin
            next_cycle();
            ReqValid = 2'b10; ReqOpcode = {OP_RD, OP_RD}; ReqAddress = {32'h200, 32'h0};
            C2F_RspValidQ502H = 1'b0;
            if (c == 4) send_rsp(OP_RD_RSP, 2'd1, 32'hDEAD_BEEF);
            @(negedge QClk);
            n_cmp++;
            if (ReqReady !== ((c == 0 || c == 5) ? 2'b10 : 2'b00)) begin n_fail++;
                $display("FAIL rd_block c=%0d: got %b", c, ReqReady); end
            n_cmp++;
            if (RspValid !== ((c == 4) ? 2'b10 : 2'b00)) begin n_fail++;
                $display("FAIL rd_rspvalid c=%0d: got %b", c, RspValid); end
            if (c == 4) begin
                n_cmp++;
                if (RspData !== 32'hDEAD_BEEF) begin n_fail++;
                    $display("FAIL rd_rspdata: got %h want deadbeef", RspData); end
            end
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        next_cycle();
        ReqValid = 2'b01; ReqOpcode = {OP_WR, OP_RD};
        @(negedge QClk);
        n_cmp++;
        if (ReqReady !== 2'b01) begin n_fail++; $display("FAIL tmo_grant: got %b want 01", ReqReady); end
        for (int c = 1; c <= 19; c++) begin
            next_cycle();
            ReqValid = (c == 19) ? 2'b01 : 2'b00;
            C2F_RspValidQ502H = 1'b0;
            if (c == 18) send_rsp(OP_RD_RSP, 2'd0, 32'hCAFE_0000);
            @(negedge QClk);
            n_cmp++;
            if (RspTimeout !== ((c == TMO) ? 2'b01 : 2'b00)) begin n_fail++;
                $display("FAIL tmo_pulse c=%0d: got %b", c, RspTimeout); end
            if (c == 18) begin
                n_cmp++;
                if (RspValid !== 2'b00) begin n_fail++; $display("FAIL tmo_late_rsp: got %b want 00", RspValid); end
            end
            if (c == 19) begin
                n_cmp++;
                if (ReqReady !== 2'b01) begin n_fail++; $display("FAIL tmo_regrant: got %b want 01", ReqReady); end
            end
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_bad_rsp();
        do_reset();
        next_cycle();
        send_rsp(OP_RD_RSP, 2'd3, 32'h3333_3333);
        @(negedge QClk);
        n_cmp++;
        if (RspValid !== 2'b00) begin n_fail++; $display("FAIL bad_tid3: got %b want 00", RspValid); end
        next_cycle();
        send_rsp(OP_RD_RSP, 2'd0, 32'h0);
        @(negedge QClk);
        n_cmp++;
        if (RspValid !== 2'b00) begin n_fail++; $display("FAIL bad_nopend: got %b want 00", RspValid); end
        next_cycle();
        C2F_RspValidQ502H = 1'b0;
        ReqValid = 2'b01; ReqOpcode = {OP_WR, OP_RD};
        next_cycle();
        ReqValid = 2'b00;
        send_rsp(OP_WR, 2'd0, 32'h1);
        @(negedge QClk);
        n_cmp++;
        if (RspValid !== 2'b00) begin n_fail++; $display("FAIL bad_opcode: got %b want 00", RspValid); end
        next_cycle();
        send_rsp(OP_RD_RSP, 2'd3, 32'h2);
        @(negedge QClk);
        n_cmp++;
        if (RspValid !== 2'b00) begin n_fail++; $display("FAIL bad_tid3_pend: got %b want 00", RspValid); end
        next_cycle();
        send_rsp(OP_RD_RSP, 2'd0, 32'h0BAD_F00D);
        @(negedge QClk);
        n_cmp++;
        if (RspValid !== 2'b01 || RspData !== 32'h0BAD_F00D) begin n_fail++;
            $display("FAIL bad_then_good: got %b %h want 01 0badf00d", RspValid, RspData); end
        next_cycle();
        clear_inputs();
    endtask

    // Reference model: pending flag and grant cycle stamp per requester, pointer, held output request.
    task automatic test_random();
        bit          m_pend [4];
        int          m_gcyc [4];
        int          m_ptr, cyc, g, i, tid;
        bit          m_ov;
        logic [1:0]  m_op, m_tid;
        logic [31:0] m_addr, m_data, e_rdata;
        logic [3:0]  e_rsp;
        logic [1:0]  e_rdy, e_to;
        do_reset();
        for (int k = 0; k < 4; k++) begin m_pend[k] = 1'b0; m_gcyc[k] = 0; end
        m_ptr = 0; m_ov = 1'b0; m_op = OP_RD; m_tid = 0; m_addr = 0; m_data = 0; cyc = 0;
        for (int n = 0; n < 500; n++) begin
            next_cycle();
            C2F_RspStall = ($urandom_range(0, 3) == 0);
            ReqValid     = 2'($urandom);
            for (int r = 0; r < NREQ; r++) begin
                ReqOpcode[2*r +: 2]   = ($urandom_range(0, 1) == 1) ? OP_RD : OP_WR;
                ReqAddress[32*r +: 32] = $urandom;
                ReqData[32*r +: 32]    = $urandom;
            end
            C2F_RspValidQ502H    = ($urandom_range(0, 2) == 0);
            C2F_RspOpcodeQ502H   = ($urandom_range(0, 4) == 0) ? OP_WR : OP_RD_RSP;
            C2F_RspThreadIDQ502H = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(2, 3))
                                                                : 2'($urandom_range(0, 1));
            C2F_RspDataQ502H     = $urandom;

            g = -1; e_rdy = '0;
            if (!C2F_RspStall) begin
                for (int k = 0; k < NREQ; k++) begin
                    i = (m_ptr + k) % NREQ;
                    if (g < 0 && ReqValid[i] && !(ReqOpcode[2*i +: 2] == OP_RD && m_pend[i])) g = i;
                end
            end
            if (g >= 0) e_rdy[g] = 1'b1;
            e_rsp = '0; e_rdata = '0;
            tid = int'(C2F_RspThreadIDQ502H);
            if (C2F_RspValidQ502H && C2F_RspOpcodeQ502H == OP_RD_RSP && tid < NREQ && m_pend[tid]) begin
                e_rsp[tid] = 1'b1;
                e_rdata    = C2F_RspDataQ502H;
            end
            e_to = '0;
            for (int k = 0; k < NREQ; k++)
                e_to[k] = m_pend[k] && (cyc - m_gcyc[k] == TMO) && !e_rsp[k];

            @(negedge QClk);
            n_cmp++;
            if (ReqReady !== e_rdy) begin n_fail++; $display("FAIL rnd_ready n=%0d: got %b want %b", n, ReqReady, e_rdy); end
            n_cmp++;
            if (RspValid !== e_rsp[1:0]) begin n_fail++; $display("FAIL rnd_rspvalid n=%0d: got %b want %b", n, RspValid, e_rsp[1:0]); end
            if (e_rsp != 0) begin
                n_cmp++;
                if (RspData !== e_rdata) begin n_fail++; $display("FAIL rnd_rspdata n=%0d: got %h want %h", n, RspData, e_rdata); end
            end
            n_cmp++;
            if (RspTimeout !== e_to) begin n_fail++; $display("FAIL rnd_timeout n=%0d: got %b want %b", n, RspTimeout, e_to); end
            n_cmp++;
            if (C2F_ReqValidQ500H !== m_ov) begin n_fail++; $display("FAIL rnd_c2f_valid n=%0d: got %b want %b", n, C2F_ReqValidQ500H, m_ov); end
            if (m_ov) begin
                n_cmp++;
                if (C2F_ReqOpcodeQ500H !== m_op || C2F_ReqThreadIDQ500H !== m_tid ||
                    C2F_ReqAddressQ500H !== m_addr || C2F_ReqDataQ500H !== m_data) begin n_fail++;
                    $display("FAIL rnd_c2f_fields n=%0d: got %0d %0d %h %h want %0d %0d %h %h", n,
                        C2F_ReqOpcodeQ500H, C2F_ReqThreadIDQ500H, C2F_ReqAddressQ500H, C2F_ReqDataQ500H,
                        m_op, m_tid, m_addr, m_data); end
            end

            for (int k = 0; k < NREQ; k++) if (e_rsp[k] || e_to[k]) m_pend[k] = 1'b0;
            if (g >= 0) begin
                m_ov   = 1'b1;
                m_op   = ReqOpcode[2*g +: 2];
                m_tid  = 2'(g);
                m_addr = ReqAddress[32*g +: 32];
                m_data = ReqData[32*g +: 32];
                m_ptr  = (g + 1) % NREQ;
                if (m_op == OP_RD) begin m_pend[g] = 1'b1; m_gcyc[g] = cyc; end
            end else if (!C2F_RspStall) begin
                m_ov = 1'b0;
            end
            cyc++;
        end
        next_cycle();
        clear_inputs();
    endtask

    initial begin
        RstQnnnL = 1'b0;
        clear_inputs();
        test_reset();
        test_wr_alternate();
        test_stall_hold();
        test_rd_response();
        test_timeout();
        test_bad_rsp();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
